sdram_word_bridge: RTL and testbench

Upstream front-end for the byte-wide SDRAM controller. It accepts 32-bit word reads and writes with byte enables from the CPU/bus side. Each access is split into sequential single-byte request/done transactions toward the controller, and one acknowledge with assembled read data is returned. The block serialises accesses, so the controller never sees a new request before the previous one completes.

---
 rtl/sdram_bridge_pkg.sv | 27 ++
 rtl/sdram_word_bridge_if.sv | 27 ++
 rtl/sdram_be_next_lane.sv | 28 ++
 rtl/sdram_word_bridge.sv | 189 ++++++++++++++++++
 tb/tb_sdram_word_bridge.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_bridge_pkg.sv
// Shared definitions for the SDRAM word bridge: FSM state encoding,
// bus-width legality check and lane index width helper.
package sdram_bridge_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] ISSUE_ENC = 2'd1;
  localparam logic [1:0] WAIT_ENC  = 2'd2;
  localparam logic [1:0] RESP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE_ENC,
    ST_ISSUE = ISSUE_ENC,
    ST_WAIT  = WAIT_ENC,
    ST_RESP  = RESP_ENC
  } state_t;

  // Only 16-bit and 32-bit bus words are supported.
  function automatic bit word_bytes_legal(input int wb);
    return (wb == 2) || (wb == 4);
  endfunction

  // Width of a byte-lane index; at least one bit.
  function automatic int lane_w(input int wb);
    return (wb <= 2) ? 1 : $clog2(wb);
  endfunction

endpackage

// File: rtl/sdram_word_bridge_if.sv
// CPU/bus side of the SDRAM word bridge: one word access per req/ack.
// master = bus requester, slave = bridge.
interface sdram_word_bridge_if #(
  parameter int SD_ADDR_W  = 23,
  parameter int WORD_BYTES = 4
) ();

  logic                    req;
  logic                    wren;
  logic [SD_ADDR_W-1:0]    addr;
  logic [8*WORD_BYTES-1:0] wdata;
  logic [WORD_BYTES-1:0]   be;
  logic [8*WORD_BYTES-1:0] rdata;
  logic                    ack;
  logic                    busy;

  modport master (
    output req, wren, addr, wdata, be,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, wren, addr, wdata, be,
    output rdata, ack, busy
  );

endinterface

// File: rtl/sdram_be_next_lane.sv
// Priority encoder: finds the lowest enabled byte lane strictly above the
// current lane, or the lowest enabled lane overall when starting a word.
module sdram_be_next_lane
  import sdram_bridge_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  localparam int LW = lane_w(WORD_BYTES)
) (
  input  logic [WORD_BYTES-1:0] i_be,
  input  logic [LW-1:0]         i_lane,
  input  logic                  i_from_start,
  output logic [LW-1:0]         o_next_lane,
  output logic                  o_has_next
);

  // Scan from the top down so the lowest qualifying lane wins.
  always_comb begin
    o_next_lane = '0;
    o_has_next  = 1'b0;
    for (int k = WORD_BYTES - 1; k >= 0; k--) begin
      if (i_be[k] && (i_from_start || (k > int'(i_lane)))) begin
        o_next_lane = LW'(k);
        o_has_next  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_word_bridge.sv
// Word-to-byte bridge in front of the byte-wide SDRAM controller.
// Each bus access is split into one request/done per enabled byte lane,
// issued strictly one at a time, followed by a single ack.
// Optional build macro SDRAM_BRIDGE_LASTWORD_CACHE_EN adds a one-entry
// last-word cache that lets fully valid read hits skip the SDRAM.
//
// state | meaning
// IDLE  | waiting for a bus request
// ISSUE | one-cycle request pulse for the current lane
// WAIT  | holding address/data until the controller signals done
// RESP  | one-cycle ack with assembled read data
module sdram_word_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int SD_ADDR_W  = 23,
  parameter int WORD_BYTES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sdram_word_bridge_if.slave   bus_if,
  output logic                 o_sd_request,
  output logic                 o_sd_wren,
  output logic [SD_ADDR_W-1:0] o_sd_address,
  output logic [7:0]           o_sd_data,
  input  logic [7:0]           i_sd_data,
  input  logic                 i_sd_done
);

  localparam int LW = lane_w(WORD_BYTES);
  localparam int DW = 8 * WORD_BYTES;

  if (!word_bytes_legal(WORD_BYTES)) begin : g_bad_width
    $error("sdram_word_bridge: WORD_BYTES must be 2 or 4");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_wren;
  logic [SD_ADDR_W-1:0]  r_base;
  logic [DW-1:0]         r_wdata;
  logic [DW-1:0]         r_rbuf;
  logic [DW-1:0]         r_rdata;
  logic [WORD_BYTES-1:0] r_be;
  logic [LW-1:0]         r_lane;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_done_wait;
  logic [SD_ADDR_W-1:0]  w_base_in;
  logic [WORD_BYTES-1:0] w_be_in;
  logic [WORD_BYTES-1:0] w_be_sel;
  logic [LW-1:0]         w_next_lane;
  logic                  w_has_next;
  logic                  w_hit;
  logic [DW-1:0]         w_rbuf_nxt;
  logic                  w_req;
  logic                  w_ack;
  logic                  w_busy;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle && bus_if.req;
  assign w_done_wait = (r_state == ST_WAIT) && i_sd_done;
  assign w_base_in   = bus_if.addr & ~SD_ADDR_W'(WORD_BYTES - 1);
  // Reads always fetch the whole word.
  assign w_be_in     = bus_if.wren ? bus_if.be : '1;
  assign w_be_sel    = w_idle ? w_be_in : r_be;

  sdram_be_next_lane #(.WORD_BYTES(WORD_BYTES)) u_next_lane (
    .i_be         (w_be_sel),
    .i_lane       (r_lane),
    .i_from_start (w_idle),
    .o_next_lane  (w_next_lane),
    .o_has_next   (w_has_next)
  );

`ifdef SDRAM_BRIDGE_LASTWORD_CACHE_EN
  logic [SD_ADDR_W-1:0]  r_c_addr;
  logic [DW-1:0]         r_c_data;
  logic [WORD_BYTES-1:0] r_c_valid;

  assign w_hit = !bus_if.wren && (r_c_addr == w_base_in) && (&r_c_valid);

  // Cache update on completion: reads fill the word, writes merge enabled
  // bytes into a matching entry or allocate a fresh one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c_addr  <= '0;
      r_c_data  <= '0;
      r_c_valid <= '0;
    end else if (r_state == ST_RESP) begin
      r_c_addr <= r_base;
      if (!r_wren) begin
        r_c_data  <= r_rdata;
        r_c_valid <= '1;
      end else begin
        r_c_valid <= (r_c_addr == r_base) ? (r_c_valid | r_be) : r_be;
        for (int k = 0; k < WORD_BYTES; k++) begin
          if (r_be[k]) r_c_data[8*k +: 8] <= r_wdata[8*k +: 8];
        end
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // Read buffer with the arriving byte merged into the current lane.
  always_comb begin
    w_rbuf_nxt = r_rbuf;
    w_rbuf_nxt[{r_lane, 3'b000} +: 8] = i_sd_data;
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and strobes; no enabled lane at acceptance means a
  // be=0 write, which completes without SDRAM traffic.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_ack       = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus_if.req) begin
          if (w_hit || !w_has_next) w_state_nxt = ST_RESP;
          else                      w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_req       = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_sd_done) w_state_nxt = w_has_next ? ST_ISSUE : ST_RESP;
      end
      ST_RESP: begin
        w_ack       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Access latching, lane stepping and read-data assembly. o_rdata only
  // changes when a read finishes so it stays stable between reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wren  <= 1'b0;
      r_base  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_lane  <= '0;
      r_rbuf  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_wren  <= bus_if.wren;
        r_base  <= w_base_in;
        r_wdata <= bus_if.wdata;
        r_be    <= w_be_in;
        r_lane  <= w_next_lane;
`ifdef SDRAM_BRIDGE_LASTWORD_CACHE_EN
        if (w_hit) r_rdata <= r_c_data;
`endif
      end
      if (w_done_wait) begin
        if (!r_wren) begin
          r_rbuf <= w_rbuf_nxt;
          if (!w_has_next) r_rdata <= w_rbuf_nxt;
        end
        if (w_has_next) r_lane <= w_next_lane;
      end
    end
  end

  assign o_sd_request   = w_req;
  assign o_sd_wren      = r_wren;
  assign o_sd_address   = r_base + SD_ADDR_W'(r_lane);
  assign o_sd_data      = r_wdata[{r_lane, 3'b000} +: 8];
  assign bus_if.ack     = w_ack;
  assign bus_if.busy    = w_busy;
  assign bus_if.rdata   = r_rdata;

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Scoreboard bench for sdram_word_bridge: stimulus pushes hand-computed
// expected SDRAM requests and acks; a monitor pops and compares them.
module tb_sdram_word_bridge;

  localparam int AW = 23;
  localparam int WB = 4;
`ifdef SDRAM_BRIDGE_LASTWORD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic          w;
    logic [7:0]    d;
  } req_t;

  typedef struct {
    logic        rd;
    logic [31:0] d;
  } ack_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sd_request;
  logic          sd_wren;
  logic [AW-1:0] sd_address;
  logic [7:0]    sd_data;
  logic [7:0]    sd_rdata = 8'h00;
  logic          sd_done = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_req_seen = 0;
  int   lat = 1;
  req_t exp_req[$];
  ack_t exp_ack[$];
  logic [7:0] mem [logic [AW-1:0]];

  always #5 clk = ~clk;

  sdram_word_bridge_if #(.SD_ADDR_W(AW), .WORD_BYTES(WB)) bif ();

  sdram_word_bridge #(.SD_ADDR_W(AW), .WORD_BYTES(WB)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bus_if       (bif),
    .o_sd_request (sd_request),
    .o_sd_wren    (sd_wren),
    .o_sd_address (sd_address),
    .o_sd_data    (sd_data),
    .i_sd_data    (sd_rdata),
    .i_sd_done    (sd_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic w, input logic [7:0] d);
    req_t r;
    r.a = a; r.w = w; r.d = d;
    exp_req.push_back(r);
  endtask

  task automatic push_ack(input logic rd, input logic [31:0] d);
    ack_t k;
    k.rd = rd; k.d = d;
    exp_ack.push_back(k);
  endtask

  // SDRAM controller model: done arrives 'lat' cycles after the request.
  initial begin
    logic [AW-1:0] a;
    logic          w;
    logic [7:0]    d;
    int            l;
    forever begin
      @(negedge clk);
      if (sd_request) begin
        a = sd_address; w = sd_wren; d = sd_data; l = lat;
        repeat (l) @(posedge clk);
        #1;
        if (w) mem[a] = d;
        else   sd_rdata = mem.exists(a) ? mem[a] : 8'h00;
        sd_done = 1'b1;
        @(posedge clk);
        #1 sd_done = 1'b0;
      end
    end
  end

  // Monitor: every request and ack must match the head of its queue.
  initial begin
    req_t r;
    ack_t k;
    forever begin
      @(negedge clk);
      if (sd_request) begin
        n_req_seen++;
        chk("req_not_in_done_cycle", sd_done, 1'b0);
        if (exp_req.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: addr 0x%0h wren %0b seen, none expected", sd_address, sd_wren);
        end else begin
          r = exp_req.pop_front();
          chk("req_addr", sd_address, r.a);
          chk("req_wren", sd_wren, r.w);
          if (r.w) chk("req_data", sd_data, r.d);
        end
      end
      if (bif.ack) begin
        if (exp_ack.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_ack: rdata 0x%0h seen, none expected", bif.rdata);
        end else begin
          k = exp_ack.pop_front();
          chk("ack_busy", bif.busy, 1'b1);
          if (k.rd) chk("ack_rdata", bif.rdata, k.d);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    chk("idle_before_issue", bif.busy, 1'b0);
    bif.req = 1'b1; bif.wren = w; bif.addr = a; bif.wdata = d; bif.be = be;
    @(posedge clk);
    #1 bif.req = 1'b0;
  endtask

  task automatic wait_ack(input string name, input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bif.ack) begin got = 1'b1; break; end
    end
    chk({name, "_ack_seen"}, got, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drained(input string name);
    chk({name, "_req_queue_empty"}, exp_req.size(), 0);
    chk({name, "_ack_queue_empty"}, exp_ack.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit found;
    bif.req = 1'b0; bif.wren = 1'b0; bif.addr = '0; bif.wdata = '0; bif.be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", bif.ack, 1'b0);
    chk("reset_busy", bif.busy, 1'b0);
    chk("reset_rdata", bif.rdata, 32'h0);
    chk("reset_sd_request", sd_request, 1'b0);
    chk("reset_sd_addr", sd_address, 23'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word write; low address bits ignored.
    push_req(23'h100, 1'b1, 8'h44);
    push_req(23'h101, 1'b1, 8'h33);
    push_req(23'h102, 1'b1, 8'h22);
    push_req(23'h103, 1'b1, 8'h11);
    push_ack(1'b0, 32'h0);
    issue(1'b1, 23'h000103, 32'h11223344, 4'b1111);
    wait_ack("wr_full", 40);
    drained("wr_full");

    // Read back; be is ignored for reads (a cache hit skips the SDRAM).
    if (!CACHE) begin
      push_req(23'h100, 1'b0, 8'h00);
      push_req(23'h101, 1'b0, 8'h00);
      push_req(23'h102, 1'b0, 8'h00);
      push_req(23'h103, 1'b0, 8'h00);
    end
    push_ack(1'b1, 32'h11223344);
    issue(1'b0, 23'h000100, 32'h0, 4'b0000);
    wait_ack("rd_full", 40);
    drained("rd_full");

    // Sparse write: lanes 0 and 2 only.
    push_req(23'h200, 1'b1, 8'hDD);
    push_req(23'h202, 1'b1, 8'hBB);
    push_ack(1'b0, 32'h0);
    issue(1'b1, 23'h000200, 32'hAABBCCDD, 4'b0101);
    wait_ack("wr_sparse", 40);
    drained("wr_sparse");

    // be=0 write: RESP right after the accepting edge, no SDRAM traffic.
    push_ack(1'b0, 32'h0);
    issue(1'b1, 23'h000400, 32'hDEADBEEF, 4'b0000);
    chk("be0_ack_next_cycle", bif.ack, 1'b1);
    @(posedge clk);
    #1;
    chk("be0_idle_after_ack", bif.busy, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    drained("wr_be0");

    // Requests while busy are dropped.
    lat = 3;
    push_req(23'h300, 1'b1, 8'h88);
    push_req(23'h301, 1'b1, 8'h77);
    push_ack(1'b0, 32'h0);
    issue(1'b1, 23'h000300, 32'h55667788, 4'b0011);
    for (int p = 0; p < 3; p++) begin
      chk("busy_during_pulse", bif.busy, 1'b1);
      bif.req = 1'b1; bif.wren = 1'b1; bif.addr = 23'h500; bif.be = 4'b1111;
      @(posedge clk);
      #1 bif.req = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_ack("busy_pulse", 40);
    repeat (4) @(posedge clk);
    #1;
    drained("busy_pulse");

    // Reset while waiting on byte 2 of a read; the late done is ignored.
    lat = 5;
    push_req(23'h100, 1'b0, 8'h00);
    push_req(23'h101, 1'b0, 8'h00);
    push_req(23'h102, 1'b0, 8'h00);
    base = n_req_seen;
    issue(1'b0, 23'h000100, 32'h0, 4'b1111);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (n_req_seen == base + 3) begin found = 1'b1; break; end
    end
    chk("rst_third_req_seen", found, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bif.busy, 1'b0);
    chk("midrst_rdata", bif.rdata, 32'h0);
    chk("midrst_sd_addr", sd_address, 23'h0);
    chk("midrst_sd_wren_data", {sd_wren, sd_data, sd_request, bif.ack}, 11'h0);
    exp_req.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("after_rst_idle", bif.busy, 1'b0);
    lat = 1;
    drained("mid_reset");

    // Normal read after reset; unwritten bytes read as zero.
    push_req(23'h200, 1'b0, 8'h00);
    push_req(23'h201, 1'b0, 8'h00);
    push_req(23'h202, 1'b0, 8'h00);
    push_req(23'h203, 1'b0, 8'h00);
    push_ack(1'b1, 32'h00BB00DD);
    issue(1'b0, 23'h000202, 32'h0, 4'b1111);
    wait_ack("rd_after_rst", 40);
    drained("rd_after_rst");

`ifdef SDRAM_BRIDGE_LASTWORD_CACHE_EN
    push_req(23'h100, 1'b0, 8'h00);
    push_req(23'h101, 1'b0, 8'h00);
    push_req(23'h102, 1'b0, 8'h00);
    push_req(23'h103, 1'b0, 8'h00);
    push_ack(1'b1, 32'h11223344);
    issue(1'b0, 23'h000100, 32'h0, 4'b1111);
    wait_ack("c_miss", 40);
    drained("c_miss");

    push_ack(1'b1, 32'h11223344);
    issue(1'b0, 23'h000100, 32'h0, 4'b1111);
    chk("c_hit_ack_next_cycle", bif.ack, 1'b1);
    wait_ack("c_hit", 4);
    drained("c_hit");

    push_req(23'h100, 1'b1, 8'h77);
    push_ack(1'b0, 32'h0);
    issue(1'b1, 23'h000100, 32'h00000077, 4'b0001);
    wait_ack("c_wr", 40);
    drained("c_wr");

    push_ack(1'b1, 32'h11223377);
    issue(1'b0, 23'h000100, 32'h0, 4'b1111);
    chk("c_hit2_ack_next_cycle", bif.ack, 1'b1);
    wait_ack("c_hit2", 4);
    drained("c_hit2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
